star_box_finder: RTL
====================

Name: star_box_finder

Overview:
Upstream feeder for the star-cleaning stage. It raster-scans the 160x120, 3-bit framebuffer through a synchronous read port. On each lit pixel it grows a bounding box around the star, then hands the box to the cleaner with a goClean pulse. It waits for doneClean, counts the star, and resumes the scan until the whole frame has been covered.

Parameters:
xSz, 8, x coordinate width
ySz, 7, y coordinate width
colSz, 3, pixel colour width
addrSz, 15, framebuffer address width
XMAX, 159, last column
YMAX, 119, last row
THRESH, 1, a pixel is lit when pixIn >= THRESH (unsigned)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
goFind  in  1  start-scan pulse; honoured only in IDLE
rdAddr  out  addrSz  framebuffer read address = probeY*160 + probeX
pixIn  in  colSz  read data, valid one cycle after rdAddr is presented
xLeft, xRight  out  xSz  box columns, inclusive
yTop, yBottom  out  ySz  box rows, inclusive
goClean  out  1  one-cycle pulse; box is stable from this pulse until doneClean
doneClean  in  1  cleaner-finished pulse; honoured only in CLEAN_WAIT
starCount  out  8  stars found this scan, saturates at 255
busy  out  1  high in every state except IDLE and DONE
doneFind  out  1  one-cycle pulse when the scan completes

Behaviour:
- Reset, also when asserted mid-operation:
  - state goes to IDLE.
  - All outputs are 0: box, rdAddr, starCount, goClean, doneFind, busy.
  - Probe and scan counters are 0.
- Probes: every probe is an _ADDR cycle (rdAddr driven from the probe counters) followed by an _EVAL cycle (pixIn sampled). Each probe costs 2 cycles.
- IDLE: on goFind, starCount goes to 0, scan position (sx,sy) goes to (0,0), next state SCAN_ADDR.
- SCAN_EVAL, lit:
  - x0 = sx; xLeft = xRight = sx; yTop = yBottom = sy.
  - Go to RIGHT with probe sx+1. If sx == XMAX, go straight to LEFT.
- SCAN_EVAL, not lit: advance the raster (x wraps at XMAX to 0 and y increments). After probing (XMAX,YMAX), go to DONE.
- RIGHT_EVAL:
  - lit: xRight = probeX; continue at probeX+1 unless probeX == XMAX, in which case go to LEFT.
  - not lit: go to LEFT.
- LEFT: the same as RIGHT, descending from x0-1. It updates xLeft and stops at column 0. If x0 == 0, LEFT is skipped.
- ROW:
  - If yBottom == YMAX, go to CLEAN_REQ.
  - Otherwise set r = yBottom+1. Latch lo = max(xLeft-1, 0) and hi = min(xRight+1, XMAX) at row start, then probe lo..hi.
  - For each lit pixel: rowHit = 1; if px < xLeft then xLeft = px; if px > xRight then xRight = px.
  - After probing hi: if rowHit, set yBottom = r and start the next row; otherwise go to CLEAN_REQ.
  - Net effect: widening is at most 1 column per side per row.
- CLEAN_REQ: goClean is high for exactly 1 cycle, then go to CLEAN_WAIT.
- CLEAN_WAIT: hold until doneClean. Then starCount += 1 (saturating at 255) and resume SCAN_ADDR at the raster successor of (sx,sy). If (sx,sy) is (XMAX,YMAX), go to DONE instead.
- DONE: doneFind is high for 1 cycle, then IDLE.
- Ignored inputs:
  - goFind is ignored while busy.
  - doneClean outside CLEAN_WAIT is ignored.
  - A goFind in the same cycle as reset is ignored; reset wins.
- Lit pixels of the same star that fall outside the grown box are not merged. If the cleaner leaves them, later scan positions detect them as separate stars.
- All coordinate arithmetic is clamped; no wrap below 0 or above XMAX/YMAX.
- rdAddr is 0 outside the _ADDR and _EVAL states.

Test Plan:
1. All-black frame, goFind -> goClean never asserts; doneFind pulses exactly 38400 cycles after the first SCAN_ADDR cycle; starCount = 0.
2. Single pixel value 7 at (10,20); bench model blacks out the box and pulses doneClean 5 cycles after goClean -> one goClean with box (10,10,20,20); starCount = 1; doneFind pulses.
3. Plus-shaped star {(50,39),(49,40),(50,40),(51,40),(50,41)} -> box xLeft = 49, xRight = 51, yTop = 39, yBottom = 41.
4. 2x2 star at columns 158..159, rows 118..119 -> box (158,159,118,119); no probe beyond x = 159 or y = 119; no address above 19199.
5. Two stars at (5,5) and (100,60); model cleans each box -> goClean order is (5,5) box then (100,60) box; final starCount = 2.
6. Reset asserted during CLEAN_WAIT -> next cycle busy = 0, starCount = 0, box = 0; a later doneClean is ignored. THRESH = 4 with a pixel value of 3 -> not detected.

Source files
------------

// File: rtl/star_box_finder_if.sv
// ---------------------------------------------------------------------------
// star_box_finder_if
// Bundles every non-clock/reset signal of the star box finder.
//   i_goFind     : start-scan pulse
//   o_rdAddr     : framebuffer read address (probeY*(XMAX+1) + probeX)
//   i_pixIn      : framebuffer read data, one cycle after o_rdAddr
//   o_xLeft/o_xRight/o_yTop/o_yBottom : inclusive bounding box of a star
//   o_goClean    : one-cycle request to the cleaner, box stable until i_doneClean
//   i_doneClean  : cleaner finished pulse
//   o_starCount  : stars found in the current scan, saturating at 255
//   o_busy       : high while a scan is in progress
//   o_doneFind   : one-cycle pulse at the end of a scan
// Modports: master = the finder itself, slave = framebuffer/cleaner/controller.
// ---------------------------------------------------------------------------
interface star_box_finder_if #(
   parameter int xSz    = 8,
   parameter int ySz    = 7,
   parameter int colSz  = 3,
   parameter int addrSz = 15
);
   logic              i_goFind;
   logic [addrSz-1:0] o_rdAddr;
   logic [colSz-1:0]  i_pixIn;
   logic [xSz-1:0]    o_xLeft;
   logic [xSz-1:0]    o_xRight;
   logic [ySz-1:0]    o_yTop;
   logic [ySz-1:0]    o_yBottom;
   logic              o_goClean;
   logic              i_doneClean;
   logic [7:0]        o_starCount;
   logic              o_busy;
   logic              o_doneFind;

   modport master (
      input  i_goFind, i_pixIn, i_doneClean,
      output o_rdAddr, o_xLeft, o_xRight, o_yTop, o_yBottom,
             o_goClean, o_starCount, o_busy, o_doneFind
   );

   modport slave (
      output i_goFind, i_pixIn, i_doneClean,
      input  o_rdAddr, o_xLeft, o_xRight, o_yTop, o_yBottom,
             o_goClean, o_starCount, o_busy, o_doneFind
   );
endinterface

// File: rtl/star_box_finder.sv
// ---------------------------------------------------------------------------
// star_box_finder
// Raster-scans the framebuffer through a synchronous read port. On each lit
// pixel it grows a bounding box (right run, left run, then row by row
// downward), hands the box to the cleaner with a goClean pulse, waits for
// doneClean, counts the star and resumes the scan.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous, active-high reset
//   bus     : star_box_finder_if.master (see interface header)
// ---------------------------------------------------------------------------
module star_box_finder #(
   parameter int xSz    = 8,
   parameter int ySz    = 7,
   parameter int colSz  = 3,
   parameter int addrSz = 15,
   parameter int XMAX   = 159,
   parameter int YMAX   = 119,
   parameter int THRESH = 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   star_box_finder_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_SCAN_ADDR  = 4'd1,
      S_SCAN_EVAL  = 4'd2,
      S_RIGHT_ADDR = 4'd3,
      S_RIGHT_EVAL = 4'd4,
      S_LEFT_ADDR  = 4'd5,
      S_LEFT_EVAL  = 4'd6,
      S_ROW_START  = 4'd7,
      S_ROW_ADDR   = 4'd8,
      S_ROW_EVAL   = 4'd9,
      S_CLEAN_REQ  = 4'd10,
      S_CLEAN_WAIT = 4'd11,
      S_DONE       = 4'd12
   } state_t;

   localparam logic [xSz-1:0]    X_LAST   = xSz'(XMAX);
   localparam logic [xSz-1:0]    X_ZERO   = {xSz{1'b0}};
   localparam logic [xSz-1:0]    X_ONE    = xSz'(1);
   localparam logic [ySz-1:0]    Y_LAST   = ySz'(YMAX);
   localparam logic [ySz-1:0]    Y_ZERO   = {ySz{1'b0}};
   localparam logic [ySz-1:0]    Y_ONE    = ySz'(1);
   localparam logic [colSz-1:0]  C_THRESH = colSz'(THRESH);
   localparam logic [addrSz-1:0] A_PITCH  = addrSz'(XMAX + 1);
   localparam logic [addrSz-1:0] A_ZERO   = {addrSz{1'b0}};

   state_t            r_state, w_state_nxt;
   // sx/sy: raster scan position; px/py: current probe; x0: column of the seed pixel
   logic [xSz-1:0]    r_sx, r_px, r_x0, r_lo, r_hi, r_xLeft, r_xRight;
   logic [xSz-1:0]    w_sx_nxt, w_px_nxt, w_x0_nxt, w_lo_nxt, w_hi_nxt, w_xLeft_nxt, w_xRight_nxt;
   logic [ySz-1:0]    r_sy, r_py, r_row, r_yTop, r_yBottom;
   logic [ySz-1:0]    w_sy_nxt, w_py_nxt, w_row_nxt, w_yTop_nxt, w_yBottom_nxt;
   logic              r_rowHit, w_rowHit_nxt;
   logic [7:0]        r_starCount, w_starCount_nxt;
   logic [addrSz-1:0] r_rdAddr, w_rdAddr_nxt;
   logic              r_goClean, r_busy, r_doneFind;

   logic              w_lit, w_scan_last, w_row_hit_now;
   logic [xSz-1:0]    w_sx_succ;
   logic [ySz-1:0]    w_sy_succ;

   assign w_lit         = (bus.i_pixIn >= C_THRESH);
   assign w_scan_last   = (r_sx == X_LAST) && (r_sy == Y_LAST);
   assign w_sx_succ     = (r_sx == X_LAST) ? X_ZERO : (r_sx + X_ONE);
   assign w_sy_succ     = (r_sx == X_LAST) ? (r_sy + Y_ONE) : r_sy;
   assign w_row_hit_now = r_rowHit | w_lit;

   // Next-state and next-value logic for the scan/grow/clean sequence
   always_comb begin
      w_state_nxt     = r_state;
      w_sx_nxt        = r_sx;
      w_sy_nxt        = r_sy;
      w_px_nxt        = r_px;
      w_py_nxt        = r_py;
      w_x0_nxt        = r_x0;
      w_lo_nxt        = r_lo;
      w_hi_nxt        = r_hi;
      w_row_nxt       = r_row;
      w_rowHit_nxt    = r_rowHit;
      w_xLeft_nxt     = r_xLeft;
      w_xRight_nxt    = r_xRight;
      w_yTop_nxt      = r_yTop;
      w_yBottom_nxt   = r_yBottom;
      w_starCount_nxt = r_starCount;
      case (r_state)
         S_IDLE: begin
            if (bus.i_goFind) begin
               w_starCount_nxt = 8'd0;
               w_sx_nxt        = X_ZERO;
               w_sy_nxt        = Y_ZERO;
               w_px_nxt        = X_ZERO;
               w_py_nxt        = Y_ZERO;
               w_state_nxt     = S_SCAN_ADDR;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SCAN_ADDR:  w_state_nxt = S_SCAN_EVAL;
         S_SCAN_EVAL: begin
            if (w_lit) begin
               w_x0_nxt      = r_sx;
               w_xLeft_nxt   = r_sx;
               w_xRight_nxt  = r_sx;
               w_yTop_nxt    = r_sy;
               w_yBottom_nxt = r_sy;
               // A seed in the last column has no right run; it cannot be column 0
               if (r_sx == X_LAST) begin
                  w_px_nxt    = r_sx - X_ONE;
                  w_state_nxt = S_LEFT_ADDR;
               end else begin
                  w_px_nxt    = r_sx + X_ONE;
                  w_state_nxt = S_RIGHT_ADDR;
               end
            end else if (w_scan_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_sx_nxt    = w_sx_succ;
               w_sy_nxt    = w_sy_succ;
               w_px_nxt    = w_sx_succ;
               w_py_nxt    = w_sy_succ;
               w_state_nxt = S_SCAN_ADDR;
            end
         end
         S_RIGHT_ADDR: w_state_nxt = S_RIGHT_EVAL;
         S_RIGHT_EVAL: begin
            if (w_lit && (r_px != X_LAST)) begin
               w_xRight_nxt = r_px;
               w_px_nxt     = r_px + X_ONE;
               w_state_nxt  = S_RIGHT_ADDR;
            end else begin
               if (w_lit) begin
                  w_xRight_nxt = r_px;
               end else begin
                  w_xRight_nxt = r_xRight;
               end
               // Right run finished: start the left run unless the seed sits in column 0
               if (r_x0 == X_ZERO) begin
                  w_state_nxt = S_ROW_START;
               end else begin
                  w_px_nxt    = r_x0 - X_ONE;
                  w_state_nxt = S_LEFT_ADDR;
               end
            end
         end
         S_LEFT_ADDR:  w_state_nxt = S_LEFT_EVAL;
         S_LEFT_EVAL: begin
            if (w_lit && (r_px != X_ZERO)) begin
               w_xLeft_nxt = r_px;
               w_px_nxt    = r_px - X_ONE;
               w_state_nxt = S_LEFT_ADDR;
            end else begin
               if (w_lit) begin
                  w_xLeft_nxt = r_px;
               end else begin
                  w_xLeft_nxt = r_xLeft;
               end
               w_state_nxt = S_ROW_START;
            end
         end
         S_ROW_START: begin
            if (r_yBottom == Y_LAST) begin
               w_state_nxt = S_CLEAN_REQ;
            end else begin
               // Probe window is latched here so in-row widening cannot extend it
               w_row_nxt    = r_yBottom + Y_ONE;
               w_py_nxt     = r_yBottom + Y_ONE;
               w_lo_nxt     = (r_xLeft == X_ZERO) ? X_ZERO : (r_xLeft - X_ONE);
               w_hi_nxt     = (r_xRight == X_LAST) ? X_LAST : (r_xRight + X_ONE);
               w_px_nxt     = (r_xLeft == X_ZERO) ? X_ZERO : (r_xLeft - X_ONE);
               w_rowHit_nxt = 1'b0;
               w_state_nxt  = S_ROW_ADDR;
            end
         end
         S_ROW_ADDR:   w_state_nxt = S_ROW_EVAL;
         S_ROW_EVAL: begin
            if (w_lit) begin
               w_rowHit_nxt = 1'b1;
               w_xLeft_nxt  = (r_px < r_xLeft) ? r_px : r_xLeft;
               w_xRight_nxt = (r_px > r_xRight) ? r_px : r_xRight;
            end else begin
               w_rowHit_nxt = r_rowHit;
            end
            if (r_px != r_hi) begin
               w_px_nxt    = r_px + X_ONE;
               w_state_nxt = S_ROW_ADDR;
            end else if (w_row_hit_now) begin
               w_yBottom_nxt = r_row;
               w_state_nxt   = S_ROW_START;
            end else begin
               w_state_nxt = S_CLEAN_REQ;
            end
         end
         S_CLEAN_REQ:  w_state_nxt = S_CLEAN_WAIT;
         S_CLEAN_WAIT: begin
            if (bus.i_doneClean) begin
               w_starCount_nxt = (r_starCount == 8'd255) ? 8'd255 : (r_starCount + 8'd1);
               if (w_scan_last) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_sx_nxt    = w_sx_succ;
                  w_sy_nxt    = w_sy_succ;
                  w_px_nxt    = w_sx_succ;
                  w_py_nxt    = w_sy_succ;
                  w_state_nxt = S_SCAN_ADDR;
               end
            end else begin
               w_state_nxt = S_CLEAN_WAIT;
            end
         end
         S_DONE:       w_state_nxt = S_IDLE;
         default:      w_state_nxt = S_IDLE;
      endcase
   end

   // Read address for the upcoming cycle; zero whenever no probe is active
   always_comb begin
      if (w_state_nxt inside {S_SCAN_ADDR, S_SCAN_EVAL, S_RIGHT_ADDR, S_RIGHT_EVAL,
                              S_LEFT_ADDR, S_LEFT_EVAL, S_ROW_ADDR, S_ROW_EVAL}) begin
         w_rdAddr_nxt = (addrSz'(w_py_nxt) * A_PITCH) + addrSz'(w_px_nxt);
      end else begin
         w_rdAddr_nxt = A_ZERO;
      end
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_sx        <= X_ZERO;
         r_sy        <= Y_ZERO;
         r_px        <= X_ZERO;
         r_py        <= Y_ZERO;
         r_x0        <= X_ZERO;
         r_lo        <= X_ZERO;
         r_hi        <= X_ZERO;
         r_row       <= Y_ZERO;
         r_rowHit    <= 1'b0;
         r_xLeft     <= X_ZERO;
         r_xRight    <= X_ZERO;
         r_yTop      <= Y_ZERO;
         r_yBottom   <= Y_ZERO;
         r_starCount <= 8'd0;
         r_rdAddr    <= A_ZERO;
         r_goClean   <= 1'b0;
         r_busy      <= 1'b0;
         r_doneFind  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sx        <= w_sx_nxt;
         r_sy        <= w_sy_nxt;
         r_px        <= w_px_nxt;
         r_py        <= w_py_nxt;
         r_x0        <= w_x0_nxt;
         r_lo        <= w_lo_nxt;
         r_hi        <= w_hi_nxt;
         r_row       <= w_row_nxt;
         r_rowHit    <= w_rowHit_nxt;
         r_xLeft     <= w_xLeft_nxt;
         r_xRight    <= w_xRight_nxt;
         r_yTop      <= w_yTop_nxt;
         r_yBottom   <= w_yBottom_nxt;
         r_starCount <= w_starCount_nxt;
         r_rdAddr    <= w_rdAddr_nxt;
         r_goClean   <= (w_state_nxt == S_CLEAN_REQ);
         r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
         r_doneFind  <= (w_state_nxt == S_DONE);
      end
   end

   assign bus.o_rdAddr    = r_rdAddr;
   assign bus.o_xLeft     = r_xLeft;
   assign bus.o_xRight    = r_xRight;
   assign bus.o_yTop      = r_yTop;
   assign bus.o_yBottom   = r_yBottom;
   assign bus.o_goClean   = r_goClean;
   assign bus.o_starCount = r_starCount;
   assign bus.o_busy      = r_busy;
   assign bus.o_doneFind  = r_doneFind;

endmodule
